// File: rtl/para_regs_pkg.sv
// Shared constants and types for the multi-channel parameter register bank.
package para_regs_pkg;

    // Defaults for the bank geometry and reset values.
    localparam int          NCH_DEF     = 4;
    localparam logic [15:0] TH_RST_DEF  = 16'h7800;
    localparam logic [31:0] HDT_RST_DEF = 32'd100000;
    localparam logic [31:0] LDT_RST_DEF = 32'd50000000;

    // Global register addresses (addr[15:0]).
    localparam logic [15:0] ADDR_DEV_ID  = 16'h0000;
    localparam logic [15:0] ADDR_NCH     = 16'h0001;
    localparam logic [15:0] ADDR_CMT_ALL = 16'h0002;
    localparam logic [15:0] ADDR_CLR_ALL = 16'h0003;

    // Channel window: channel c lives at CH_BASE + c*CH_STRIDE.
    localparam logic [15:0] CH_BASE   = 16'h0100;
    localparam logic [15:0] CH_STRIDE = 16'h0020;
    localparam int          OFS_W     = $clog2(CH_STRIDE);

    // Byte offsets inside one channel window.
    localparam logic [OFS_W-1:0] OFS_TH   = 5'h00;
    localparam logic [OFS_W-1:0] OFS_HDT  = 5'h04;
    localparam logic [OFS_W-1:0] OFS_LDT  = 5'h08;
    localparam logic [OFS_W-1:0] OFS_AVE  = 5'h10;
    localparam logic [OFS_W-1:0] OFS_HIT  = 5'h12;
    localparam logic [OFS_W-1:0] OFS_PEND = 5'h1E;
    localparam logic [OFS_W-1:0] OFS_CMT  = 5'h1F;

    // One complete parameter set (shadow or active copy).
    typedef struct packed {
        logic [15:0] th;
        logic [31:0] hdt;
        logic [31:0] ldt;
    } para_set_t;

    // Saturating 16-bit increment used by the hit counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/para_chan_regs.sv
// One channel: shadow/active parameter sets, pending flag, hit counter
// and the two snapshot registers that make 16-bit status reads coherent.
module para_chan_regs
    import para_regs_pkg::*;
#(
    parameter logic [15:0] TH_RST  = TH_RST_DEF,
    parameter logic [31:0] HDT_RST = HDT_RST_DEF,
    parameter logic [31:0] LDT_RST = LDT_RST_DEF
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [OFS_W-1:0] wofs_i,
    input  logic [7:0]       wdata_i,
    input  logic             rd_i,
    input  logic [OFS_W-1:0] rofs_i,
    input  logic             cmt_all_i,
    input  logic             clr_all_i,
    input  logic             hit_i,
    input  logic [15:0]      ave_i,
    output logic [15:0]      th_o,
    output logic [31:0]      hdt_o,
    output logic [31:0]      ldt_o,
    output logic             upd_o,
    output logic [7:0]       rdata_o
);

    localparam para_set_t RST_SET = para_set_t'({TH_RST, HDT_RST, LDT_RST});

    para_set_t   shd_q, shd_d;
    para_set_t   act_q, act_d;
    logic        pend_q, pend_d;
    logic        upd_q, upd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ave_snap_q, ave_snap_d;
    logic [15:0] hit_snap_q, hit_snap_d;
    logic        cmt_ch_s;
    logic        clr_s;
    logic        cfg_wr_s;
    logic [7:0]  rdata_s;

    assign cmt_ch_s = wr_i & (wofs_i == OFS_CMT) & wdata_i[0];
    assign clr_s    = clr_all_i | (wr_i & (wofs_i == OFS_CMT) & wdata_i[1]);

    // Shadow byte writes; cfg_wr_s marks a write that stages a change.
    always_comb begin
        shd_d    = shd_q;
        cfg_wr_s = 1'b0;
        if (wr_i) begin
            case (wofs_i)
                OFS_TH:         begin shd_d.th[7:0]    = wdata_i; cfg_wr_s = 1'b1; end
                OFS_TH + 5'd1:  begin shd_d.th[15:8]   = wdata_i; cfg_wr_s = 1'b1; end
                OFS_HDT:        begin shd_d.hdt[7:0]   = wdata_i; cfg_wr_s = 1'b1; end
                OFS_HDT + 5'd1: begin shd_d.hdt[15:8]  = wdata_i; cfg_wr_s = 1'b1; end
                OFS_HDT + 5'd2: begin shd_d.hdt[23:16] = wdata_i; cfg_wr_s = 1'b1; end
                OFS_HDT + 5'd3: begin shd_d.hdt[31:24] = wdata_i; cfg_wr_s = 1'b1; end
                OFS_LDT:        begin shd_d.ldt[7:0]   = wdata_i; cfg_wr_s = 1'b1; end
                OFS_LDT + 5'd1: begin shd_d.ldt[15:8]  = wdata_i; cfg_wr_s = 1'b1; end
                OFS_LDT + 5'd2: begin shd_d.ldt[23:16] = wdata_i; cfg_wr_s = 1'b1; end
                OFS_LDT + 5'd3: begin shd_d.ldt[31:24] = wdata_i; cfg_wr_s = 1'b1; end
                default:        begin shd_d = shd_q; cfg_wr_s = 1'b0; end
            endcase
        end else begin
            shd_d    = shd_q;
            cfg_wr_s = 1'b0;
        end
    end

    // Commit: copy shadow to active. A channel commit always pulses upd;
    // the global commit only pulses channels that had staged changes.
    always_comb begin
        act_d  = act_q;
        pend_d = pend_q;
        upd_d  = 1'b0;
        if (cmt_ch_s || cmt_all_i) begin
            act_d  = shd_q;
            pend_d = 1'b0;
            upd_d  = cmt_ch_s | pend_q;
        end else if (cfg_wr_s) begin
            act_d  = act_q;
            pend_d = 1'b1;
            upd_d  = 1'b0;
        end else begin
            act_d  = act_q;
            pend_d = pend_q;
            upd_d  = 1'b0;
        end
    end

    // Hit counter (clear has priority) and LSB-read snapshot capture.
    always_comb begin
        cnt_d      = cnt_q;
        ave_snap_d = ave_snap_q;
        hit_snap_d = hit_snap_q;
        if (clr_s) begin
            cnt_d = 16'h0000;
        end else if (hit_i) begin
            cnt_d = sat_inc16(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
        if (rd_i && (rofs_i == OFS_AVE)) begin
            ave_snap_d = ave_i;
        end else begin
            ave_snap_d = ave_snap_q;
        end
        if (rd_i && (rofs_i == OFS_HIT)) begin
            hit_snap_d = cnt_q;
        end else begin
            hit_snap_d = hit_snap_q;
        end
    end

    // Read mux: cfg offsets show the shadow, MSB status bytes the snapshot.
    always_comb begin
        rdata_s = 8'h00;
        case (rofs_i)
            OFS_TH:         rdata_s = shd_q.th[7:0];
            OFS_TH + 5'd1:  rdata_s = shd_q.th[15:8];
            OFS_HDT:        rdata_s = shd_q.hdt[7:0];
            OFS_HDT + 5'd1: rdata_s = shd_q.hdt[15:8];
            OFS_HDT + 5'd2: rdata_s = shd_q.hdt[23:16];
            OFS_HDT + 5'd3: rdata_s = shd_q.hdt[31:24];
            OFS_LDT:        rdata_s = shd_q.ldt[7:0];
            OFS_LDT + 5'd1: rdata_s = shd_q.ldt[15:8];
            OFS_LDT + 5'd2: rdata_s = shd_q.ldt[23:16];
            OFS_LDT + 5'd3: rdata_s = shd_q.ldt[31:24];
            OFS_AVE:        rdata_s = ave_i[7:0];
            OFS_AVE + 5'd1: rdata_s = ave_snap_q[15:8];
            OFS_HIT:        rdata_s = cnt_q[7:0];
            OFS_HIT + 5'd1: rdata_s = hit_snap_q[15:8];
            OFS_PEND:       rdata_s = {7'd0, pend_q};
            default:        rdata_s = 8'h00;
        endcase
        if (rd_i) begin
            rdata_o = rdata_s;
        end else begin
            rdata_o = 8'h00;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shd_q      <= RST_SET;
            act_q      <= RST_SET;
            pend_q     <= 1'b0;
            upd_q      <= 1'b0;
            cnt_q      <= 16'h0000;
            ave_snap_q <= 16'h0000;
            hit_snap_q <= 16'h0000;
        end else begin
            shd_q      <= shd_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            upd_q      <= upd_d;
            cnt_q      <= cnt_d;
            ave_snap_q <= ave_snap_d;
            hit_snap_q <= hit_snap_d;
        end
    end

    assign th_o  = act_q.th;
    assign hdt_o = act_q.hdt;
    assign ldt_o = act_q.ldt;
    assign upd_o = upd_q;

endmodule

// File: rtl/para_regs_mc.sv
// Multi-channel parameter register bank on the fx bus: address decode,
// global registers and the registered read-data path.
module para_regs_mc
    import para_regs_pkg::*;
#(
    parameter int          NCH     = NCH_DEF,
    parameter logic [15:0] TH_RST  = TH_RST_DEF,
    parameter logic [31:0] HDT_RST = HDT_RST_DEF,
    parameter logic [31:0] LDT_RST = LDT_RST_DEF
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [5:0]        dev_id,
    input  logic              fx_wr,
    input  logic [21:0]       fx_waddr,
    input  logic [7:0]        fx_data,
    input  logic              fx_rd,
    input  logic [21:0]       fx_raddr,
    output logic [7:0]        fx_q,
    output logic [NCH*16-1:0] cfg_th,
    output logic [NCH*32-1:0] cfg_hdt,
    output logic [NCH*32-1:0] cfg_ldt,
    output logic [NCH-1:0]    cfg_upd,
    input  logic [NCH*16-1:0] sta_ave,
    input  logic [NCH-1:0]    hit_pls
);

    logic       wr_s, rd_s;
    logic       wr_ch_s, rd_ch_s;
    logic       cmt_all_s, clr_all_s;
    logic [2:0] wr_idx_s, rd_idx_s;
    logic [7:0] rdata_s;
    logic [7:0] fx_q_q;
    logic [7:0] ch_rdata_s [NCH];

    assign wr_s = fx_wr & (fx_waddr[21:16] == dev_id);
    assign rd_s = fx_rd & (fx_raddr[21:16] == dev_id);

    // The whole channel window sits in one 256-byte page above CH_BASE.
    assign wr_ch_s  = wr_s & (fx_waddr[15:8] == CH_BASE[15:8]);
    assign rd_ch_s  = rd_s & (fx_raddr[15:8] == CH_BASE[15:8]);
    assign wr_idx_s = fx_waddr[OFS_W+2:OFS_W];
    assign rd_idx_s = fx_raddr[OFS_W+2:OFS_W];

    assign cmt_all_s = wr_s & (fx_waddr[15:0] == ADDR_CMT_ALL) & fx_data[0];
    assign clr_all_s = wr_s & (fx_waddr[15:0] == ADDR_CLR_ALL) & fx_data[0];

    // Channels beyond NCH are simply not built, so they decode to nothing.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        para_chan_regs #(
            .TH_RST  (TH_RST),
            .HDT_RST (HDT_RST),
            .LDT_RST (LDT_RST)
        ) u_chan (
            .clk_sys   (clk_sys),
            .rst_n     (rst_n),
            .wr_i      (wr_ch_s & (wr_idx_s == 3'(c))),
            .wofs_i    (fx_waddr[OFS_W-1:0]),
            .wdata_i   (fx_data),
            .rd_i      (rd_ch_s & (rd_idx_s == 3'(c))),
            .rofs_i    (fx_raddr[OFS_W-1:0]),
            .cmt_all_i (cmt_all_s),
            .clr_all_i (clr_all_s),
            .hit_i     (hit_pls[c]),
            .ave_i     (sta_ave[16*c +: 16]),
            .th_o      (cfg_th[16*c +: 16]),
            .hdt_o     (cfg_hdt[32*c +: 32]),
            .ldt_o     (cfg_ldt[32*c +: 32]),
            .upd_o     (cfg_upd[c]),
            .rdata_o   (ch_rdata_s[c])
        );
    end

    // Read data: global registers OR-ed with the (already gated) channels.
    always_comb begin
        rdata_s = 8'h00;
        if (rd_s) begin
            case (fx_raddr[15:0])
                ADDR_DEV_ID: rdata_s = {2'b00, dev_id};
                ADDR_NCH:    rdata_s = 8'(NCH);
                default:     rdata_s = 8'h00;
            endcase
            for (int c = 0; c < NCH; c++) begin
                rdata_s = rdata_s | ch_rdata_s[c];
            end
        end else begin
            rdata_s = 8'h00;
        end
    end

    // Registered read data; zero whenever no selected read was issued.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_q_q <= 8'h00;
        end else begin
            fx_q_q <= rdata_s;
        end
    end

    assign fx_q = fx_q_q;

endmodule

// File: tb/tb_para_regs_mc.sv
// Self-checking bench for para_regs_mc against a behavioural register model.
`timescale 1ns/1ps
module tb_para_regs_mc;

    localparam int NCH = 4;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic [5:0]        dev_id;
    logic              fx_wr;
    logic [21:0]       fx_waddr;
    logic [7:0]        fx_data;
    logic              fx_rd;
    logic [21:0]       fx_raddr;
    logic [7:0]        fx_q;
    logic [NCH*16-1:0] cfg_th;
    logic [NCH*32-1:0] cfg_hdt;
    logic [NCH*32-1:0] cfg_ldt;
    logic [NCH-1:0]    cfg_upd;
    logic [NCH*16-1:0] sta_ave;
    logic [NCH-1:0]    hit_pls;

    int checks = 0;
    int errors = 0;

    para_regs_mc #(.NCH(NCH)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .dev_id   (dev_id),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .cfg_th   (cfg_th),
        .cfg_hdt  (cfg_hdt),
        .cfg_ldt  (cfg_ldt),
        .cfg_upd  (cfg_upd),
        .sta_ave  (sta_ave),
        .hit_pls  (hit_pls)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- behavioural model ----------------
    logic [15:0] m_sh_th  [NCH];
    logic [15:0] m_act_th [NCH];
    logic [31:0] m_sh_hdt [NCH];
    logic [31:0] m_act_hdt[NCH];
    logic [31:0] m_sh_ldt [NCH];
    logic [31:0] m_act_ldt[NCH];
    logic        m_pend   [NCH];
    int          m_cnt    [NCH];
    logic [15:0] m_ave_snap[NCH];
    logic [15:0] m_hit_snap[NCH];
    logic [NCH-1:0] m_clr;

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sh_th[c] = 16'h7800;     m_act_th[c] = 16'h7800;
            m_sh_hdt[c] = 32'd100000;  m_act_hdt[c] = 32'd100000;
            m_sh_ldt[c] = 32'd50000000; m_act_ldt[c] = 32'd50000000;
            m_pend[c] = 1'b0; m_cnt[c] = 0;
            m_ave_snap[c] = 16'h0000; m_hit_snap[c] = 16'h0000;
        end
        m_clr = '0;
    endfunction

    // Returns -1 for addresses outside the built channel windows.
    function automatic int m_chan(input logic [15:0] la);
        if (la < 16'h0100 || int'(la) >= 256 + NCH * 32) return -1;
        return (int'(la) - 256) / 32;
    endfunction

    function automatic logic [7:0] m_read(input logic [21:0] a);
        logic [15:0] la;
        int c, o;
        if (a[21:16] != dev_id) return 8'h00;
        la = a[15:0];
        if (la == 16'h0000) return {2'b00, dev_id};
        if (la == 16'h0001) return 8'(NCH);
        c = m_chan(la);
        if (c < 0) return 8'h00;
        o = (int'(la) - 256) % 32;
        if (o <= 1) return 8'(m_sh_th[c] >> (8 * o));
        if (o >= 4 && o <= 7) return 8'(m_sh_hdt[c] >> (8 * (o - 4)));
        if (o >= 8 && o <= 11) return 8'(m_sh_ldt[c] >> (8 * (o - 8)));
        if (o == 16) begin m_ave_snap[c] = sta_ave[16*c +: 16]; return m_ave_snap[c][7:0]; end
        if (o == 17) return m_ave_snap[c][15:8];
        if (o == 18) begin m_hit_snap[c] = 16'(m_cnt[c]); return m_hit_snap[c][7:0]; end
        if (o == 19) return m_hit_snap[c][15:8];
        if (o == 30) return {7'd0, m_pend[c]};
        return 8'h00;
    endfunction

    function automatic void m_commit(input int c);
        m_act_th[c] = m_sh_th[c]; m_act_hdt[c] = m_sh_hdt[c]; m_act_ldt[c] = m_sh_ldt[c];
        m_pend[c] = 1'b0;
    endfunction

    // Applies a write; returns the cfg_upd pattern expected after the edge.
    function automatic logic [NCH-1:0] m_write(input logic [21:0] a, input logic [7:0] d);
        logic [NCH-1:0] upd = '0;
        logic [15:0] la;
        int c, o;
        m_clr = '0;
        if (a[21:16] != dev_id) return upd;
        la = a[15:0];
        if (la == 16'h0002 && d[0]) begin
            for (int k = 0; k < NCH; k++) begin
                if (m_pend[k]) upd[k] = 1'b1;
                m_commit(k);
            end
        end else if (la == 16'h0003 && d[0]) begin
            m_clr = '1;
        end else begin
            c = m_chan(la);
            if (c >= 0) begin
                o = (int'(la) - 256) % 32;
                if (o <= 1) begin
                    m_sh_th[c] = (m_sh_th[c] & ~(16'h00FF << (8*o))) | (16'(d) << (8*o));
                    m_pend[c] = 1'b1;
                end else if (o >= 4 && o <= 7) begin
                    m_sh_hdt[c] = (m_sh_hdt[c] & ~(32'h00FF << (8*(o-4)))) | (32'(d) << (8*(o-4)));
                    m_pend[c] = 1'b1;
                end else if (o >= 8 && o <= 11) begin
                    m_sh_ldt[c] = (m_sh_ldt[c] & ~(32'h00FF << (8*(o-8)))) | (32'(d) << (8*(o-8)));
                    m_pend[c] = 1'b1;
                end else if (o == 31) begin
                    if (d[0]) begin upd[c] = 1'b1; m_commit(c); end
                    if (d[1]) m_clr[c] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NCH; k++) if (m_clr[k]) m_cnt[k] = 0;
        return upd;
    endfunction

    function automatic void m_hits(input logic [NCH-1:0] h, input logic [NCH-1:0] clr);
        for (int c = 0; c < NCH; c++)
            if (h[c] && !clr[c] && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
    endfunction

    function automatic logic [NCH*16-1:0] m_cfg_th();
        logic [NCH*16-1:0] v;
        for (int c = 0; c < NCH; c++) v[16*c +: 16] = m_act_th[c];
        return v;
    endfunction

    function automatic logic [NCH*64-1:0] m_cfg_dt();
        logic [NCH*64-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            v[32*c +: 32] = m_act_hdt[c];
            v[NCH*32 + 32*c +: 32] = m_act_ldt[c];
        end
        return v;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [NCH-1:0] h);
        fx_waddr = a; fx_data = d; fx_wr = 1'b1; hit_pls = h;
        @(posedge clk_sys); #1;
        fx_wr = 1'b0; hit_pls = '0;
    endtask

    task automatic do_read(input logic [21:0] a, input logic [NCH-1:0] h, output logic [7:0] q);
        fx_raddr = a; fx_rd = 1'b1; hit_pls = h;
        @(posedge clk_sys); #1;
        fx_rd = 1'b0; hit_pls = '0;
        q = fx_q;
    endtask

    task automatic do_idle();
        @(posedge clk_sys); #1;
    endtask

    function automatic logic [21:0] ad(input logic [15:0] la);
        return {dev_id, la};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] q, e;
        rst_n = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0; hit_pls = '0;
        fx_waddr = '0; fx_raddr = '0; fx_data = '0; sta_ave = '0; dev_id = 6'h05;
        m_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        checks++;
        if (fx_q !== 8'h00 || cfg_upd !== 4'b0000) begin
            errors++; $display("FAIL reset_q_upd fx_q=%h cfg_upd=%b want 00/0000", fx_q, cfg_upd);
        end
        checks++;
        if (cfg_th[15:0] !== 16'h7800 || cfg_hdt[31:0] !== 32'd100000 || cfg_th !== m_cfg_th()
            || {cfg_ldt, cfg_hdt} !== m_cfg_dt()) begin
            errors++; $display("FAIL reset_cfg th=%h hdt=%h ldt=%h", cfg_th, cfg_hdt, cfg_ldt);
        end
        rst_n = 1'b1;
        do_idle();
        do_read(ad(16'h0000), '0, q);
        checks++;
        if (q !== 8'h05) begin errors++; $display("FAIL dev_id_read got %h want 05", q); end
        do_read(ad(16'h0001), '0, q);
        checks++;
        if (q !== 8'h04) begin errors++; $display("FAIL nch_read got %h want 04", q); end
        sta_ave[31:16] = 16'hAB00;
        e = m_read(ad(16'h0131));
        do_read(ad(16'h0131), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e) begin errors++; $display("FAIL msb_no_snapshot got %h want 00", q); end
    endtask

    task automatic test_shadow_commit();
        logic [7:0] q;
        logic [NCH-1:0] u;
        u = m_write(ad(16'h0120), 8'h34); do_write(ad(16'h0120), 8'h34, '0);
        u = m_write(ad(16'h0121), 8'h12); do_write(ad(16'h0121), 8'h12, '0);
        checks++;
        if (cfg_th[31:16] !== 16'h7800) begin errors++; $display("FAIL shadow_hidden th1=%h want 7800", cfg_th[31:16]); end
        do_read(ad(16'h013E), '0, q);
        checks++;
        if (q !== 8'h01) begin errors++; $display("FAIL pend_set got %h want 01", q); end
        do_read(ad(16'h0120), '0, q);
        checks++;
        if (q !== 8'h34) begin errors++; $display("FAIL shadow_readback got %h want 34", q); end
        u = m_write(ad(16'h013F), 8'h01); do_write(ad(16'h013F), 8'h01, '0);
        checks++;
        if (cfg_th[31:16] !== 16'h1234 || cfg_upd !== 4'b0010 || cfg_upd !== u) begin
            errors++; $display("FAIL ch_commit th1=%h upd=%b want 1234/0010", cfg_th[31:16], cfg_upd);
        end
        do_idle();
        checks++;
        if (cfg_upd !== 4'b0000) begin errors++; $display("FAIL upd_one_cycle upd=%b want 0000", cfg_upd); end
        do_read(ad(16'h013E), '0, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL pend_clear got %h want 00", q); end
    endtask

    task automatic test_commit_all();
        logic [NCH-1:0] u;
        logic [7:0] d;
        logic [NCH*16-1:0] th_before;
        th_before = cfg_th;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom); u = m_write(ad(16'h0100 + 16'(i)), d); do_write(ad(16'h0100 + 16'(i)), d, '0);
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom); u = m_write(ad(16'h0168 + 16'(i)), d); do_write(ad(16'h0168 + 16'(i)), d, '0);
        end
        checks++;
        if (cfg_th !== th_before || cfg_upd !== 4'b0000) begin
            errors++; $display("FAIL commit_all_pre th=%h upd=%b", cfg_th, cfg_upd);
        end
        u = m_write(ad(16'h0002), 8'h01); do_write(ad(16'h0002), 8'h01, '0);
        checks++;
        if (cfg_upd !== 4'b1001 || cfg_upd !== u || cfg_th !== m_cfg_th() || {cfg_ldt, cfg_hdt} !== m_cfg_dt()) begin
            errors++; $display("FAIL commit_all upd=%b want 1001 th=%h want %h", cfg_upd, cfg_th, m_cfg_th());
        end
        do_idle();
        checks++;
        if (cfg_upd !== 4'b0000) begin errors++; $display("FAIL commit_all_pulse upd=%b want 0000", cfg_upd); end
    endtask

    task automatic test_snapshot();
        logic [7:0] q, e;
        sta_ave[15:0] = 16'h00FF;
        e = m_read(ad(16'h0110)); do_read(ad(16'h0110), '0, q);
        checks++;
        if (q !== 8'hFF || q !== e) begin errors++; $display("FAIL snap_lsb got %h want FF", q); end
        sta_ave[15:0] = 16'h0100;
        e = m_read(ad(16'h0111)); do_read(ad(16'h0111), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e) begin errors++; $display("FAIL snap_msb got %h want 00", q); end
        e = m_read(ad(16'h0110)); do_read(ad(16'h0110), '0, q);
        e = m_read(ad(16'h0111)); do_read(ad(16'h0111), '0, q);
        checks++;
        if (q !== 8'h01 || q !== e) begin errors++; $display("FAIL snap_refresh got %h want 01", q); end
    endtask

    task automatic test_hit_saturate();
        logic [7:0] q, e;
        logic [NCH-1:0] u;
        hit_pls = 4'b0100;
        repeat (70000) @(posedge clk_sys);
        #1 hit_pls = '0;
        m_hits(4'b0100, '0);
        for (int i = 1; i < 70000; i++) m_hits(4'b0100, '0);
        e = m_read(ad(16'h0152)); do_read(ad(16'h0152), '0, q);
        checks++;
        if (q !== 8'hFF || q !== e) begin errors++; $display("FAIL hit_sat_lsb got %h want FF", q); end
        e = m_read(ad(16'h0153)); do_read(ad(16'h0153), '0, q);
        checks++;
        if (q !== 8'hFF || q !== e) begin errors++; $display("FAIL hit_sat_msb got %h want FF", q); end
        u = m_write(ad(16'h015F), 8'h02); m_hits(4'b0100, m_clr);
        do_write(ad(16'h015F), 8'h02, 4'b0100);
        e = m_read(ad(16'h0152)); do_read(ad(16'h0152), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e) begin errors++; $display("FAIL clear_wins_lsb got %h want 00", q); end
        e = m_read(ad(16'h0153)); do_read(ad(16'h0153), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e) begin errors++; $display("FAIL clear_wins_msb got %h want 00", q); end
    endtask

    task automatic test_unmapped();
        logic [7:0] q;
        logic [NCH-1:0] u;
        logic [NCH*16-1:0] th_before;
        th_before = cfg_th;
        u = m_write(ad(16'h01A0), 8'h5A); do_write(ad(16'h01A0), 8'h5A, '0);
        u = m_write(ad(16'h01BF), 8'h01); do_write(ad(16'h01BF), 8'h01, '0);
        checks++;
        if (cfg_th !== th_before || cfg_upd !== 4'b0000) begin
            errors++; $display("FAIL ch5_write th=%h upd=%b", cfg_th, cfg_upd);
        end
        do_read(ad(16'h01A0), '0, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL ch5_read got %h want 00", q); end
        do_read({dev_id ^ 6'h01, 16'h0000}, '0, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL devid_mismatch got %h want 00", q); end
        do_read(ad(16'h0102), '0, q);
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL unmapped_ofs got %h want 00", q); end
        do_read(ad(16'h0000), '0, q);
        do_idle();
        checks++;
        if (fx_q !== 8'h00) begin errors++; $display("FAIL idle_q got %h want 00", fx_q); end
    endtask

    task automatic test_rw_same_cycle();
        logic [7:0] e, d;
        logic [NCH-1:0] u;
        d = ~m_read(ad(16'h0121));
        e = m_read(ad(16'h0121));
        u = m_write(ad(16'h0121), d);
        fx_waddr = ad(16'h0121); fx_data = d; fx_wr = 1'b1;
        fx_raddr = ad(16'h0121); fx_rd = 1'b1;
        @(posedge clk_sys); #1;
        fx_wr = 1'b0; fx_rd = 1'b0;
        checks++;
        if (fx_q !== e) begin errors++; $display("FAIL rw_pre_value got %h want %h", fx_q, e); end
    endtask

    task automatic test_random();
        int ofs_tab [18] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 16, 17, 18, 19, 30, 31};
        logic [21:0] a;
        logic [7:0] q, e, d;
        logic [NCH-1:0] h, u;
        int c, o, sel;
        for (int i = 0; i < 400; i++) begin
            sta_ave = {$urandom(), $urandom()};
            h = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            c = $urandom_range(0, 5);
            o = ofs_tab[$urandom_range(0, 17)];
            sel = $urandom_range(0, 19);
            if (sel == 0) a = {dev_id ^ 6'h01, 16'h0100 + 16'(c*32 + o)};
            else if (sel <= 2) a = ad(16'($urandom_range(0, 3)));
            else a = ad(16'h0100 + 16'(c*32 + o));
            if ($urandom_range(0, 1) == 0) begin
                d = 8'($urandom);
                u = m_write(a, d); m_hits(h, m_clr);
                do_write(a, d, h);
                checks++;
                if (cfg_upd !== u || cfg_th !== m_cfg_th() || {cfg_ldt, cfg_hdt} !== m_cfg_dt()) begin
                    errors++;
                    $display("FAIL rand_write a=%h d=%h upd=%b want %b th=%h want %h", a, d, cfg_upd, u, cfg_th, m_cfg_th());
                end
            end else begin
                e = m_read(a); m_hits(h, '0);
                do_read(a, h, q);
                checks++;
                if (q !== e) begin errors++; $display("FAIL rand_read a=%h got %h want %h", a, q, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q, e;
        logic [NCH-1:0] u;
        u = m_write(ad(16'h0100), 8'hC3); do_write(ad(16'h0100), 8'hC3, '0);
        rst_n = 1'b0;
        m_reset();
        #2;
        checks++;
        if (cfg_upd !== 4'b0000 || cfg_th !== m_cfg_th()) begin
            errors++; $display("FAIL mid_reset upd=%b th=%h", cfg_upd, cfg_th);
        end
        do_idle(); do_idle();
        rst_n = 1'b1;
        e = m_read(ad(16'h0100)); do_read(ad(16'h0100), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e) begin errors++; $display("FAIL mid_reset_shadow got %h want 00", q); end
        e = m_read(ad(16'h011E)); do_read(ad(16'h011E), '0, q);
        checks++;
        if (q !== 8'h00 || q !== e || cfg_upd !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_pend got %h upd=%b want 00/0000", q, cfg_upd);
        end
    endtask

    initial begin
        test_reset();
        test_shadow_commit();
        test_commit_all();
        test_snapshot();
        test_hit_saturate();
        test_unmapped();
        test_rw_same_cycle();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/para_regs_mc.md
Name: para_regs_mc

Overview:
Multi-channel successor to the single-channel parameter register bank on the fx bus. It holds NCH independent threshold and dwell-time parameter sets behind shadow registers with atomic commit, so a multi-byte update never reaches the datapath half-written. It adds per-channel saturating hit counters and coherent snapshot reads of multi-byte status. It sits in para_top between the fx bus decoder and the per-channel detection logic.

Parameters:
NCH, 4, number of channels (1..8).
TH_RST, 16'h7800, reset value of every cfg_th channel.
HDT_RST, 32'd100000, reset value of every cfg_hdt channel.
LDT_RST, 32'd50000000, reset value of every cfg_ldt channel.

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset
dev_id  in  6  device select; matched against addr[21:16]
fx_wr  in  1  write strobe
fx_waddr  in  22  write address
fx_data  in  8  write data
fx_rd  in  1  read strobe
fx_raddr  in  22  read address
fx_q  out  8  read data, registered
cfg_th  out  NCH*16  active thresholds; channel c at [16c+15:16c]
cfg_hdt  out  NCH*32  active high dwell times
cfg_ldt  out  NCH*32  active low dwell times
cfg_upd  out  NCH  one-cycle pulse when channel c commits
sta_ave  in  NCH*16  per-channel average (status)
hit_pls  in  NCH  per-channel hit event, one clk_sys per hit

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk_sys. Reset sets active and shadow to TH_RST/HDT_RST/LDT_RST, pending=0, counters=0, snapshots=0, cfg_upd=0, fx_q=0.
- Select: wsel = (fx_waddr[21:16]==dev_id); rsel likewise. Only fx_wr&wsel writes; only fx_rd&rsel reads.
- Global map (addr[15:0]):
  - 0x0000 R dev_id zero-extended to 8 bits.
  - 0x0001 R NCH.
  - 0x0002 W bit0=1 commits all channels.
  - 0x0003 W bit0=1 clears all hit counters.
- Channel map: base 0x0100+c*0x20, c<NCH. c>=NCH: writes ignored, reads return 0.
  - +0x00..01 th shadow, LSB first.
  - +0x04..07 hdt shadow, LSB first.
  - +0x08..0B ldt shadow, LSB first.
  - +0x10..11 sta_ave (RO).
  - +0x12..13 hit count (RO).
  - +0x1E R pending in bit0.
  - +0x1F W bit0=1 commit this channel; bit1=1 clear this counter.
- Shadow writes:
  - Byte write updates the shadow only and sets pending.
  - cfg_* outputs are unchanged until commit.
  - Reads of cfg offsets return the shadow.
- Commit:
  - Next clk_sys edge after the commit write: active<=shadow, pending<=0, cfg_upd[c]=1 for exactly one cycle.
  - Commit with pending=0 still pulses cfg_upd.
- Hit counter:
  - 16-bit, +1 per hit_pls cycle, saturates at 0xFFFF (no wrap).
  - Clear and hit in the same cycle: clear wins, result 0.
- Snapshot:
  - A read of LSB offset +0x10 or +0x12 latches the full 16-bit source into that channel's snapshot register.
  - A read of the matching MSB offset returns the snapshot MSB, not the live value.
  - An MSB read without a prior LSB read returns the last snapshot (0 after reset).
- Read timing:
  - fx_q is valid one cycle after fx_rd.
  - fx_q=0 in any cycle with no selected read, and for unmapped addresses.
- Simultaneous write and read on the same cycle: the read returns the pre-write value.
- Reset mid-update: shadow bytes already written are lost and no cfg_upd pulse is issued.

Decomposition:
- Package para_regs_pkg holds:
  - channel offset constants OFS_TH, OFS_HDT, OFS_LDT, OFS_AVE, OFS_HIT, OFS_PEND, OFS_CMT;
  - CH_BASE and CH_STRIDE;
  - global addresses;
  - default reset constants.
- Sub-module para_chan_regs holds one channel's shadow, active, pending, counter and snapshots. It receives a decoded byte offset plus write and read strobes, and returns an 8-bit read mux output.
- The top level instantiates para_chan_regs NCH times via generate, does address decode, and ORs the channel read outputs into the fx_q register.

Test Plan:
1. Reset, then read 0x0000 with dev_id=6'h05 -> fx_q=8'h05 one cycle later. cfg_th[15:0]=16'h7800, cfg_hdt[31:0]=32'd100000, all cfg_upd=0.
2. Write ch1 0x0120=8'h34 and 0x0121=8'h12 -> cfg_th[31:16] still 16'h7800 and 0x013E reads 1. Write 0x013F=8'h01 -> cfg_th[31:16]=16'h1234, cfg_upd=4'b0010 for one cycle, 0x013E reads 0.
3. Load shadows of ch0 and ch3, then write 0x0002=8'h01 -> both channels update on the same edge, cfg_upd=4'b1001 for one cycle.
4. Drive 70000 hit_pls cycles on ch2 -> 0x0152/0x0153 read 8'hFF/8'hFF. Write 0x015F=8'h02 coincident with hit_pls[2] -> count reads 0.
5. Set sta_ave ch0=16'h00FF and read 0x0110. Change it to 16'h0100, then read 0x0111 -> returns 8'h00 (snapshot), not 8'h01.
6. With NCH=4, write 0x01A0 (ch5) -> no state change. Reading it, and reading dev_id mismatch, -> fx_q=0. Assert rst_n low after one shadow byte write -> shadow back to default, pending=0, no cfg_upd.
